// File: rtl/nic_if.sv
// Bundle of CPU memory-mapped port and router local-port signals seen by the NIC.
// The NIC takes the slave modport; the CPU/router side takes master.
interface nic_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic [0:1]            nicAddr;
  logic [0:DATA_WIDTH-1] nicDataIn;
  logic [0:DATA_WIDTH-1] nicDataOut;
  logic                  nicEn;
  logic                  nicWrEn;

  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;

  modport slave (
    input  nicAddr, nicDataIn, nicEn, nicWrEn, net_ro, net_si, net_di,
    output nicDataOut, net_so, net_do, net_ri
  );

  modport master (
    output nicAddr, nicDataIn, nicEn, nicWrEn, net_ro, net_si, net_di,
    input  nicDataOut, net_so, net_do, net_ri
  );
endinterface

// File: rtl/nic.sv
// Single-packet NIC: one output buffer (CPU to router) and one input buffer
// (router to CPU), each with a full flag visible to the CPU.
module nic #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic   clk,
  input logic   reset,
  nic_if.slave  bus
);

  localparam logic [0:1] AddrOutBuf  = 2'b00;
  localparam logic [0:1] AddrOutStat = 2'b01;
  localparam logic [0:1] AddrInBuf   = 2'b10;
  localparam logic [0:1] AddrInStat  = 2'b11;

  logic [0:DATA_WIDTH-1] out_buf_q, out_buf_d;
  logic [0:DATA_WIDTH-1] in_buf_q, in_buf_d;
  logic                  out_full_q, out_full_d;
  logic                  in_full_q, in_full_d;
  logic [0:DATA_WIDTH-1] data_out_q, data_out_d;
  logic                  net_so_q, net_so_d;
  logic [0:DATA_WIDTH-1] net_do_q, net_do_d;

  logic cpu_wr, cpu_rd, inject, eject;

  always_comb begin
    cpu_wr = bus.nicEn & bus.nicWrEn;
    cpu_rd = bus.nicEn & ~bus.nicWrEn;
    inject = out_full_q & bus.net_ro;
    // A packet arriving while full is a router fault; it is simply ignored.
    eject  = bus.net_si & ~in_full_q;
  end

  // Output channel: a write while full is dropped, even on the injection edge.
  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    net_so_d   = 1'b0;
    net_do_d   = net_do_q;
    if (inject) begin
      out_full_d = 1'b0;
      net_so_d   = 1'b1;
      net_do_d   = out_buf_q;
    end else if (cpu_wr && bus.nicAddr == AddrOutBuf && !out_full_q) begin
      out_buf_d  = bus.nicDataIn;
      out_full_d = 1'b1;
    end
  end

  // Input channel: eject needs empty, the clearing read needs full, so they never collide.
  always_comb begin
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    if (eject) begin
      in_buf_d  = bus.net_di;
      in_full_d = 1'b1;
    end else if (cpu_rd && bus.nicAddr == AddrInBuf && in_full_q) begin
      in_full_d = 1'b0;
    end
  end

  // CPU read data: status reads return the pre-edge flag value.
  always_comb begin
    data_out_d = data_out_q;
    if (cpu_rd) begin
      unique case (bus.nicAddr)
        AddrOutBuf:  data_out_d = out_buf_q;
        AddrOutStat: data_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
        AddrInBuf:   data_out_d = in_buf_q;
        AddrInStat:  data_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
        default:     data_out_d = data_out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf_q  <= '0;
      in_buf_q   <= '0;
      out_full_q <= 1'b0;
      in_full_q  <= 1'b0;
      data_out_q <= '0;
      net_so_q   <= 1'b0;
      net_do_q   <= '0;
    end else begin
      out_buf_q  <= out_buf_d;
      in_buf_q   <= in_buf_d;
      out_full_q <= out_full_d;
      in_full_q  <= in_full_d;
      data_out_q <= data_out_d;
      net_so_q   <= net_so_d;
      net_do_q   <= net_do_d;
    end
  end

  assign bus.nicDataOut = data_out_q;
  assign bus.net_so     = net_so_q;
  assign bus.net_do     = net_do_q;
  assign bus.net_ri     = ~in_full_q;

endmodule

// File: tb/tb_nic.sv
// Directed bench for nic: each task drives one scenario and checks outputs 1ns after the edge.
module tb_nic;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  nic_if #(.DATA_WIDTH(64)) bus ();

  nic #(.DATA_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [0:1] a, input logic [0:63] d);
    bus.nicAddr   = a;
    bus.nicDataIn = d;
    bus.nicEn     = 1'b1;
    bus.nicWrEn   = 1'b1;
    tick();
    bus.nicEn     = 1'b0;
    bus.nicWrEn   = 1'b0;
  endtask

  task automatic cpu_read(input logic [0:1] a, output logic [0:63] d);
    bus.nicAddr = a;
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b0;
    tick();
    bus.nicEn   = 1'b0;
    d = bus.nicDataOut;
  endtask

  task automatic test_reset();
    logic [0:63] r;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.nicDataOut !== 64'h0 || bus.net_so !== 1'b0 || bus.net_do !== 64'h0 ||
        bus.net_ri !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: dout=%h so=%b do=%h ri=%b, want 0 0 0 1",
               bus.nicDataOut, bus.net_so, bus.net_do, bus.net_ri);
    end
    // Load out_buf with the router stalled, make nicDataOut nonzero, then reset.
    bus.net_ro = 1'b0;
    cpu_write(2'b00, 64'hDEAD_BEEF_0000_0001);
    cpu_read(2'b00, r);
    checks++;
    if (r !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL reset_preload: got %h want deadbeef00000001", r);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.nicDataOut !== 64'h0 || bus.net_so !== 1'b0 || bus.net_do !== 64'h0 ||
        bus.net_ri !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_op: dout=%h so=%b do=%h ri=%b, want 0 0 0 1",
               bus.nicDataOut, bus.net_so, bus.net_do, bus.net_ri);
    end
    bus.net_ro = 1'b1;
    tick();
    checks++;
    if (bus.net_so !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: net_so=%b want 0", bus.net_so);
    end
    cpu_read(2'b01, r);
    checks++;
    if (r !== 64'h0) begin
      errors++;
      $display("FAIL reset_status: got %h want 0", r);
    end
  endtask

  task automatic test_injection();
    logic [0:63] r;
    bus.net_ro = 1'b1;
    cpu_write(2'b00, 64'h0123_4567_89AB_CDEF);
    checks++;
    if (bus.net_so !== 1'b0) begin
      errors++;
      $display("FAIL inj_early: net_so=%b want 0", bus.net_so);
    end
    tick();
    checks++;
    if (bus.net_so !== 1'b1 || bus.net_do !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL inj_pulse: so=%b do=%h want 1 0123456789abcdef", bus.net_so, bus.net_do);
    end
    tick();
    checks++;
    if (bus.net_so !== 1'b0 || bus.net_do !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL inj_one_cycle: so=%b do=%h want 0 0123456789abcdef",
               bus.net_so, bus.net_do);
    end
    cpu_read(2'b01, r);
    checks++;
    if (r !== 64'h0) begin
      errors++;
      $display("FAIL inj_status: got %h want 0", r);
    end
  endtask

  task automatic test_backpressure();
    logic [0:63] r;
    int pulses;
    bus.net_ro = 1'b0;
    cpu_write(2'b00, 64'h1);
    cpu_write(2'b00, 64'h2);
    cpu_read(2'b01, r);
    checks++;
    if (r !== 64'h1) begin
      errors++;
      $display("FAIL bp_status: got %h want 1", r);
    end
    cpu_read(2'b00, r);
    checks++;
    if (r !== 64'h1) begin
      errors++;
      $display("FAIL bp_drop: out_buf got %h want 1", r);
    end
    checks++;
    if (bus.net_so !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: net_so=%b want 0", bus.net_so);
    end
    bus.net_ro = 1'b1;
    tick();
    checks++;
    if (bus.net_so !== 1'b1 || bus.net_do !== 64'h1) begin
      errors++;
      $display("FAIL bp_release: so=%b do=%h want 1 1", bus.net_so, bus.net_do);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.net_so === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL bp_single_pulse: extra pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    bus.net_ro = 1'b1;
    cpu_write(2'b00, 64'h11);
    tick();
    checks++;
    if (bus.net_so !== 1'b1 || bus.net_do !== 64'h11) begin
      errors++;
      $display("FAIL b2b_first: so=%b do=%h want 1 11", bus.net_so, bus.net_do);
    end
    cpu_write(2'b00, 64'h22);
    checks++;
    if (bus.net_so !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: net_so=%b want 0", bus.net_so);
    end
    tick();
    checks++;
    if (bus.net_so !== 1'b1 || bus.net_do !== 64'h22) begin
      errors++;
      $display("FAIL b2b_second: so=%b do=%h want 1 22", bus.net_so, bus.net_do);
    end
  endtask

  task automatic test_collision();
    logic [0:63] r;
    // Write lands on the injection edge: out_full still 1, so it is dropped.
    bus.net_ro = 1'b0;
    cpu_write(2'b00, 64'hAA);
    bus.net_ro = 1'b1;
    cpu_write(2'b00, 64'hBB);
    checks++;
    if (bus.net_so !== 1'b1 || bus.net_do !== 64'hAA) begin
      errors++;
      $display("FAIL col_inject: so=%b do=%h want 1 aa", bus.net_so, bus.net_do);
    end
    cpu_read(2'b00, r);
    checks++;
    if (r !== 64'hAA) begin
      errors++;
      $display("FAIL col_write_dropped: got %h want aa", r);
    end
    // Status read on the injection edge sees the pre-edge flag.
    bus.net_ro = 1'b0;
    cpu_write(2'b00, 64'hCC);
    bus.net_ro = 1'b1;
    cpu_read(2'b01, r);
    checks++;
    if (r !== 64'h1 || bus.net_so !== 1'b1 || bus.net_do !== 64'hCC) begin
      errors++;
      $display("FAIL col_status: stat=%h so=%b do=%h want 1 1 cc", r, bus.net_so, bus.net_do);
    end
  endtask

  task automatic test_ejection();
    logic [0:63] r;
    checks++;
    if (bus.net_ri !== 1'b1) begin
      errors++;
      $display("FAIL ej_ready: net_ri=%b want 1", bus.net_ri);
    end
    bus.net_si = 1'b1;
    bus.net_di = 64'hCAFE;
    tick();
    bus.net_si = 1'b0;
    bus.net_di = 64'h0;
    checks++;
    if (bus.net_ri !== 1'b0) begin
      errors++;
      $display("FAIL ej_ri_low: net_ri=%b want 0", bus.net_ri);
    end
    cpu_read(2'b11, r);
    checks++;
    if (r !== 64'h1) begin
      errors++;
      $display("FAIL ej_status_full: got %h want 1", r);
    end
    cpu_read(2'b10, r);
    checks++;
    if (r !== 64'hCAFE || bus.net_ri !== 1'b1) begin
      errors++;
      $display("FAIL ej_read: data=%h ri=%b want cafe 1", r, bus.net_ri);
    end
    cpu_read(2'b10, r);
    checks++;
    if (r !== 64'hCAFE) begin
      errors++;
      $display("FAIL ej_stale_read: got %h want cafe", r);
    end
    cpu_read(2'b11, r);
    checks++;
    if (r !== 64'h0) begin
      errors++;
      $display("FAIL ej_status_empty: got %h want 0", r);
    end
  endtask

  task automatic test_full_input();
    logic [0:63] r;
    bus.net_si = 1'b1;
    bus.net_di = 64'h1234;
    tick();
    bus.net_di = 64'hBAD;
    tick();
    bus.net_si = 1'b0;
    checks++;
    if (bus.net_ri !== 1'b0) begin
      errors++;
      $display("FAIL full_ri: net_ri=%b want 0", bus.net_ri);
    end
    cpu_read(2'b10, r);
    checks++;
    if (r !== 64'h1234 || bus.net_ri !== 1'b1) begin
      errors++;
      $display("FAIL full_ignore: data=%h ri=%b want 1234 1", r, bus.net_ri);
    end
  endtask

  task automatic test_illegal();
    logic [0:63] r;
    logic [0:63] held;
    bus.net_ro = 1'b0;
    cpu_write(2'b01, 64'hFFFF);
    cpu_write(2'b10, 64'hFFFF);
    cpu_write(2'b11, 64'hFFFF);
    cpu_read(2'b01, r);
    checks++;
    if (r !== 64'h0) begin
      errors++;
      $display("FAIL ill_out_status: got %h want 0", r);
    end
    cpu_read(2'b11, r);
    checks++;
    if (r !== 64'h0 || bus.net_ri !== 1'b1) begin
      errors++;
      $display("FAIL ill_in_status: got %h ri=%b want 0 1", r, bus.net_ri);
    end
    cpu_read(2'b10, r);
    checks++;
    if (r !== 64'h1234) begin
      errors++;
      $display("FAIL ill_in_buf: got %h want 1234", r);
    end
    cpu_read(2'b00, r);
    checks++;
    if (r !== 64'hCC) begin
      errors++;
      $display("FAIL ill_out_buf: got %h want cc", r);
    end
    held = 64'hCC;
    bus.nicEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.nicAddr   = 2'(i);
      bus.nicWrEn   = i[0];
      bus.nicDataIn = 64'hFFFF;
      tick();
      checks++;
      if (bus.nicDataOut !== held) begin
        errors++;
        $display("FAIL ill_en_low_%0d: dout=%h want %h", i, bus.nicDataOut, held);
      end
    end
    bus.nicWrEn = 1'b0;
    cpu_read(2'b01, r);
    checks++;
    if (r !== 64'h0) begin
      errors++;
      $display("FAIL ill_en_low_nowrite: status %h want 0", r);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.nicAddr   = 2'b00;
    bus.nicDataIn = 64'h0;
    bus.nicEn     = 1'b0;
    bus.nicWrEn   = 1'b0;
    bus.net_ro    = 1'b0;
    bus.net_si    = 1'b0;
    bus.net_di    = 64'h0;
    #1;
    test_reset();
    test_injection();
    test_backpressure();
    test_back_to_back();
    test_collision();
    test_ejection();
    test_full_input();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nic.md
# nic

Network interface controller between the CPU's memory-mapped NIC port and one ring-router local port. It holds one 64-bit output-channel buffer (CPU → network) and one 64-bit input-channel buffer (network → CPU). Each buffer has a status flag readable by the CPU. The CPU drives the port as initiator; this block is the responder, and the master on the router side.

## Interface
- Parameters:
  - DATA_WIDTH, 64: packet/data width. Bits are indexed [0:DATA_WIDTH-1], MSB = bit 0.
- Ports:
  - clk, in, 1: single clock, rising edge.
  - reset, in, 1: synchronous, active-high.
  - nicAddr, in, [0:1]: register select. 00 = output buffer, 01 = output status, 10 = input buffer, 11 = input status.
  - nicDataIn, in, [0:63]: CPU write data.
  - nicDataOut, out, [0:63]: CPU read data (registered).
  - nicEn, in, 1: access enable.
  - nicWrEn, in, 1: 1 = write, 0 = read; qualified by nicEn.
  - net_so, out, 1: send-out strobe to router.
  - net_ro, in, 1: router ready to accept a packet.
  - net_do, out, [0:63]: packet to router.
  - net_si, in, 1: send-in strobe from router.
  - net_ri, out, 1: NIC ready to accept a packet; equals ~in_full.
  - net_di, in, [0:63]: packet from router.

## Operation
- State:
  - out_buf and in_buf: 64-bit registers.
  - out_full and in_full: 1-bit flags.
- Reset (edge with reset=1): all flags and data registers clear. nicDataOut=0, net_so=0, net_do=0, net_ri=1. Reset overrides every concurrent event; an in-flight packet is discarded.
- CPU write (nicEn=1, nicWrEn=1):
  - addr 00 with out_full=0: out_buf←nicDataIn, out_full←1.
  - addr 00 with out_full=1: write dropped, buffer unchanged. Software polls status first.
  - addr 01, 10 or 11: ignored.
- CPU read (nicEn=1, nicWrEn=0): nicDataOut is loaded at the edge.
  - 00: out_buf.
  - 01: {63'b0, out_full}.
  - 10: in_buf. If in_full=1, in_full←0 at the same edge. If in_full=0, stale in_buf is returned and nothing changes.
  - 11: {63'b0, in_full}.
- nicEn=0: nicDataOut holds its last value.
- Injection, at an edge with out_full=1 and net_ro=1:
  - net_so←1 and net_do←out_buf.
  - out_full←0.
- Otherwise net_so←0 and net_do holds.
- Ejection, at an edge with net_si=1 and in_full=0: in_buf←net_di, in_full←1.
- net_si=1 while in_full=1 is a router protocol violation. The packet is ignored and in_buf is unchanged.
- Simultaneous events:
  - CPU write to 00 on the same edge as injection: out_full is still 1 before that edge, so the write is dropped.
  - Status read on the same edge as a flag change: returns the pre-edge flag value.
  - CPU read of 10 (clearing in_full) on the same edge net_si arrives: cannot occur, because net_ri=0 while full. The next packet is accepted no earlier than the following edge.
- Independence: the CPU side and the router side operate every cycle with no arbitration between them.

## Timing
- CPU read latency: 1 cycle. Read issued at edge N; data valid on nicDataOut after edge N, sampled by the CPU at edge N+1.
- Write to injection:
  - Write at edge N sets out_full.
  - If net_ro=1, edge N+1 raises net_so with net_do valid, for exactly one cycle.
  - Minimum write-to-write spacing for back-to-back packets: 2 cycles.
- net_ro low holds the packet indefinitely; there is no timeout.
- Ejection:
  - Packet captured at edge M; net_ri falls right after M.
  - Earliest CPU status read seeing in_full=1: issued at edge M+1.
  - A buffer read at edge K restores net_ri=1 after K.
- All outputs change only on the rising clk edge. net_ri is a decode of the in_full flop, not of inputs.

## Test plan
- Reset mid-operation: load out_buf with 64'hDEAD_BEEF_0000_0001 while net_ro=0, then assert reset → net_so=0, net_do=0, nicDataOut=0 and net_ri=1 after that edge; a later read of 01 returns 0.
- Injection: write 64'h0123_4567_89AB_CDEF to 00 with net_ro=1 → net_so=1 with net_do=64'h0123_4567_89AB_CDEF exactly one cycle later, lasting one cycle; read of 01 then returns 0.
- Back-pressure and drop: with net_ro=0, write A=64'h1 then B=64'h2 to 00 → status 01 reads 1, B is dropped; raise net_ro → net_do=64'h1 and net_so pulses once.
- Ejection: drive net_si=1 with net_di=64'hCAFE when net_ri=1 → net_ri=0 next cycle and read of 11 returns 1; read of 10 returns 64'hCAFE and net_ri=1 afterwards; a second read of 10 returns 64'hCAFE while 11 reads 0.
- Full input buffer: hold in_full=1, drive net_si=1 with 64'hBAD → in_buf still holds the original packet.
- Illegal writes: write 64'hFFFF to 01, 10 and 11 → no flag or buffer change; nicEn=0 with any address keeps nicDataOut constant.
